sys_bus_fabric: RTL
===================

SYS_BUS_FABRIC -- requirements
Module: sys_bus_fabric

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-003 SHALL have parameter SEL_W, default 2, slave-select width; NUM_S = 2**SEL_W slaves, selected by addr[ADDR_W-1 -: SEL_W].
REQ-004 SHALL have parameter SLAVE_MAP, default 4'b0011, one bit per slave, 1 = populated.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255, maximum wait-state cycles per access.
REQ-006 SHALL have ports: clk input 1, sole clock, rising edge; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port rst input 1, asynchronous active-high reset.
REQ-008 SHALL have ports m_req input 1 (access request), m_we input DATA_W/8 (byte write enables, all-zero = read), m_addr input ADDR_W, m_wdata input DATA_W.
REQ-009 SHALL have ports m_rdata output DATA_W, m_ready output 1 (one-cycle completion pulse), m_err output 1 (valid with m_ready).
REQ-010 SHALL have ports s_ce output NUM_S, s_we output DATA_W/8, s_addr output ADDR_W, s_wdata output DATA_W (shared across slaves).
REQ-011 SHALL have ports s_rdata input NUM_S*DATA_W (slave i at [i*DATA_W +: DATA_W]) and s_ready input NUM_S.

Function
REQ-012 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-013 In IDLE with m_req=1, SHALL register m_addr/m_we/m_wdata and go to ACCESS if the selected slave is populated, else to RESP with error flagged.
REQ-014 In ACCESS, SHALL drive s_ce one-hot for the latched slave, with s_addr/s_we/s_wdata from the latched request, all held stable.
REQ-015 In ACCESS with s_ready[sel]=1, SHALL capture s_rdata of sel (reads) or zero (writes) into m_rdata and go to RESP.
REQ-016 In RESP, SHALL assert m_ready for exactly one cycle, with m_err valid, deassert s_ce, and return to IDLE.
REQ-017 Minimum latency SHALL be 2 cycles (req at edge N, s_ce during N+1, m_ready during N+2 when s_ready is immediate).
REQ-018 m_req in ACCESS/RESP SHALL be ignored; the master holds request until m_ready.
REQ-019 Unmapped access SHALL produce no s_ce, m_rdata=0, m_err=1.
REQ-020 s_ready from non-selected slaves SHALL be ignored.
REQ-021 m_rdata SHALL hold its last value outside RESP.

Reset
REQ-022 rst SHALL asynchronously force IDLE, s_ce=0, s_we=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, timeout counter=0.
REQ-023 Reset mid-access SHALL abort with no m_ready; the first request after release is serviced normally.

Configuration
REQ-024 With BUS_TIMEOUT_EN defined, SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYC without s_ready, SHALL go to RESP with m_err=1, m_rdata=0, and the counter clears on ACCESS entry.
REQ-025 Without BUS_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic shall exist.

Structure
REQ-026 Package bus_pkg SHALL hold the FSM state encoding, the response code (OK/ERR), and default DATA_W/ADDR_W constants.
REQ-027 Sub-module bus_timeout_cnt (clear, enable, expired) SHALL be instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-028 Read: slave1 s_ready immediate, s_rdata=32'hDEADBEEF, addr=32'h4000_0010 -> s_ce=4'b0010 for 1 cycle, m_ready 2 cycles after req, m_rdata=DEADBEEF, m_err=0.
REQ-029 Write: m_we=4'b0011, addr=32'h0000_0008, wdata=32'h1234_5678, slave0 3 wait states -> s_we/s_wdata stable for 4 cycles, single m_ready pulse, m_err=0.
REQ-030 Unmapped: addr=32'hC000_0000 with SLAVE_MAP=4'b0011 -> s_ce never asserts, m_ready after 1 cycle, m_err=1, m_rdata=0.
REQ-031 Timeout (macro on, TIMEOUT_CYC=4): slave0 never ready -> m_err=1 after 4 ACCESS cycles, s_ce drops, next request succeeds.
REQ-032 Reset in ACCESS: rst pulsed during wait -> outputs zero immediately, no m_ready, later read to slave0 completes normally.
REQ-033 Back-to-back: m_req held across two transactions to slave0 then slave1 -> two m_ready pulses separated by IDLE, correct s_ce each.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the single-master system bus fabric.
package bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } bus_resp_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Access watchdog: counts enabled cycles and flags the LIMIT-th one as expired.
module bus_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of earlier enabled cycles, so the current one is number cnt_q+1.
    assign expired = enable && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_bus_fabric.sv
// Single-master to NUM_S-slave bus fabric with registered slave strobes and a one-cycle response.
// Optional access watchdog is built when BUS_TIMEOUT_EN is defined.
module sys_bus_fabric
    import bus_pkg::*;
#(
    parameter int                     DATA_W      = BUS_DATA_W,
    parameter int                     ADDR_W      = BUS_ADDR_W,
    parameter int                     SEL_W       = 2,
    parameter logic [(2**SEL_W)-1:0]  SLAVE_MAP   = 4'b0011,
    parameter int                     TIMEOUT_CYC = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            m_req,
    input  logic [DATA_W/8-1:0]             m_we,
    input  logic [ADDR_W-1:0]               m_addr,
    input  logic [DATA_W-1:0]               m_wdata,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            m_ready,
    output logic                            m_err,
    output logic [(2**SEL_W)-1:0]           s_ce,
    output logic [DATA_W/8-1:0]             s_we,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic [(2**SEL_W)*DATA_W-1:0]    s_rdata,
    input  logic [(2**SEL_W)-1:0]           s_ready
);

    localparam int NUM_S = 2**SEL_W;
    localparam int BE_W  = DATA_W / 8;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    bus_state_e          state_q, state_d;
    bus_resp_e           resp_q, resp_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_S-1:0]    s_ce_q, s_ce_d;
    logic [BE_W-1:0]     s_we_q, s_we_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                m_ready_q, m_ready_d;

    logic [SEL_W-1:0]    req_sel;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                to_expired;

    assign req_sel   = m_addr[ADDR_W-1 -: SEL_W];
    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
    logic to_clear;
    logic to_enable;

    // Counter sits at zero everywhere outside ACCESS, so every access starts a fresh budget.
    assign to_enable = (state_q == ST_ACCESS);
    assign to_clear  = !to_enable;

    bus_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        resp_d    = RESP_OK;
        sel_d     = sel_q;
        s_ce_d    = s_ce_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    sel_d     = req_sel;
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    if (SLAVE_MAP[req_sel]) begin
                        state_d         = ST_ACCESS;
                        s_ce_d          = '0;
                        s_ce_d[req_sel] = 1'b1;
                    end else begin
                        // Holes in the map answer straight away without touching any slave.
                        state_d   = ST_RESP;
                        resp_d    = RESP_ERR;
                        m_rdata_d = '0;
                        m_ready_d = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d   = ST_RESP;
                    s_ce_d    = '0;
                    m_ready_d = 1'b1;
                    m_rdata_d = (s_we_q == '0) ? sel_rdata : '0;
                end else if (to_expired) begin
                    state_d   = ST_RESP;
                    s_ce_d    = '0;
                    resp_d    = RESP_ERR;
                    m_rdata_d = '0;
                    m_ready_d = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                s_ce_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            resp_q    <= RESP_OK;
            sel_q     <= '0;
            s_ce_q    <= '0;
            s_we_q    <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            sel_q     <= sel_d;
            s_ce_q    <= s_ce_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ready_q <= m_ready_d;
        end
    end

    assign s_ce    = s_ce_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign m_rdata = m_rdata_q;
    assign m_ready = m_ready_q;
    assign m_err   = (resp_q == RESP_ERR);

endmodule
